// File: rtl/stack_pkg.sv
// Shared constants and state encoding for the 8-entry stack controller.
// Contents:
//   WIDTH  - default data word width
//   DEPTH  - stack entries (matches the external 8-word RAM)
//   PTR_W  - stack pointer width (holds 0..DEPTH)
//   state_t - occupancy state: EMPTY (sp=0), PARTIAL (1..7), FULL (sp=8)
package stack_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/stack_ctrl_8.sv
// Stack controller driving an external 8-word combinational-read,
// clocked-write RAM instantiated alongside it one level up.
// Optional feature: define STACK_BYPASS_EN to forward din straight to dout
// on a simultaneous push+pop while the stack is empty.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   clear              - synchronous flush (overrides push/pop)
//   push, pop, din     - requests and push data
//   dout, dout_valid   - registered popped word, one-cycle valid pulse
//   count, full, empty - occupancy
//   ovf, unf           - sticky overflow/underflow flags
//   ram_in, ram_address, ram_load, ram_out - external RAM interface
module stack_ctrl_8
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = stack_pkg::WIDTH,
    parameter int unsigned DEPTH = stack_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic [WIDTH-1:0] ram_in,
    output logic [2:0]       ram_address,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out
);

    localparam logic [PTR_W-1:0] SP_MAX = PTR_W'(DEPTH);

    logic [PTR_W-1:0] sp, sp_next;
    state_t           state, state_next;
    logic [WIDTH-1:0] dout_next;
    logic             dv_next, ovf_next, unf_next, load;

    always_comb begin
        sp_next     = sp;
        dout_next   = dout;
        dv_next     = 1'b0;
        ovf_next    = ovf;
        unf_next    = unf;
        load        = 1'b0;
        // Idle address points at the top entry; wraps to 7 when empty.
        ram_address = sp[2:0] - 3'd1;

        if (clear) begin
            sp_next  = '0;
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (state != FULL) begin
                        ram_address = sp[2:0];
                        load        = 1'b1;
                        sp_next     = sp + PTR_W'(1);
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
                2'b01: begin
                    if (state != EMPTY) begin
                        dout_next = ram_out;
                        dv_next   = 1'b1;
                        sp_next   = sp - PTR_W'(1);
                    end else begin
                        unf_next = 1'b1;
                    end
                end
                2'b11: begin
                    if (state != EMPTY) begin
                        // Replace-top: read old top and overwrite it in the same cycle.
                        load      = 1'b1;
                        dout_next = ram_out;
                        dv_next   = 1'b1;
                    end else begin
`ifdef STACK_BYPASS_EN
                        dout_next = din;
                        dv_next   = 1'b1;
`else
                        ram_address = sp[2:0];
                        load        = 1'b1;
                        sp_next     = sp + PTR_W'(1);
                        unf_next    = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end

        if (sp_next == '0)
            state_next = EMPTY;
        else if (sp_next == SP_MAX)
            state_next = FULL;
        else
            state_next = PARTIAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp         <= '0;
            state      <= EMPTY;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            sp         <= sp_next;
            state      <= state_next;
            dout       <= dout_next;
            dout_valid <= dv_next;
            ovf        <= ovf_next;
            unf        <= unf_next;
        end
    end

    assign ram_in   = din;
    assign ram_load = load & rst_n;
    assign count    = sp;
    assign empty    = (state == EMPTY);
    assign full     = (state == FULL);

endmodule

// File: tb/tb_stack_ctrl_8.sv
module tb_stack_ctrl_8;

    logic        clk = 1'b0;
    logic        rst_n, clear, push, pop;
    logic [15:0] din, dout, ram_in, ram_out;
    logic        dout_valid, full, empty, ovf, unf, ram_load;
    logic [3:0]  count;
    logic [2:0]  ram_address;

    logic [15:0] mem [8];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    stack_ctrl_8 #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop),
        .din(din), .dout(dout), .dout_valid(dout_valid), .count(count),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    // Behavioural 8x16 RAM: combinational read, clocked write, never reset.
    assign ram_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    typedef struct {
        logic        clr, psh, pp;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] dout;
        logic        dv, ovf, unf;
        logic        mchk;
        int unsigned midx;
        logic [15:0] mval;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic clr, logic psh, logic pp, logic [15:0] d,
                                logic [3:0] cnt, logic [15:0] dq, logic dv,
                                logic o, logic u, logic mchk,
                                int unsigned midx, logic [15:0] mval);
        vec_t v;
        v.clr = clr; v.psh = psh; v.pp = pp; v.din = d; v.cnt = cnt;
        v.dout = dq; v.dv = dv; v.ovf = o; v.unf = u;
        v.mchk = mchk; v.midx = midx; v.mval = mval;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] cnt, input logic [15:0] dq,
                            input logic dv, input logic o, input logic u);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".dout"}, 32'(dout), 32'(dq));
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(dv));
        chk({tag, ".ovf"}, 32'(ovf), 32'(o));
        chk({tag, ".unf"}, 32'(unf), 32'(u));
        chk({tag, ".full"}, 32'(full), 32'(cnt == 4'd8));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 4'd0));
    endtask

    task automatic step(input logic c, input logic p, input logic q, input logic [15:0] d);
        @(negedge clk);
        clear = c; push = p; pop = q; din = d;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] snap;

    initial begin
        // Basic push/pop of three words.
        add(0,1,0,16'h1111, 1,16'h0000,0,0,0, 1,0,16'h1111);
        add(0,1,0,16'h2222, 2,16'h0000,0,0,0, 1,1,16'h2222);
        add(0,1,0,16'h3333, 3,16'h0000,0,0,0, 1,2,16'h3333);
        add(0,0,1,16'h0000, 2,16'h3333,1,0,0, 0,0,16'h0000);
        add(0,0,1,16'h0000, 1,16'h2222,1,0,0, 0,0,16'h0000);
        add(0,0,1,16'h0000, 0,16'h1111,1,0,0, 0,0,16'h0000);
        add(0,0,0,16'h0000, 0,16'h1111,0,0,0, 0,0,16'h0000);
        // Underflow, then clear wipes the sticky flag but keeps dout.
        add(0,0,1,16'h0000, 0,16'h1111,0,0,1, 0,0,16'h0000);
        add(1,0,0,16'h0000, 0,16'h1111,0,0,0, 0,0,16'h0000);
        // Fill to 8, 9th push dropped with overflow.
        for (int unsigned i = 1; i <= 8; i++)
            add(0,1,0,16'(i), 4'(i),16'h1111,0,0,0, 1,i-1,16'(i));
        add(0,1,0,16'h0009, 8,16'h1111,0,1,0, 1,7,16'h0008);
        add(1,0,0,16'h0000, 0,16'h1111,0,0,0, 0,0,16'h0000);
        // Replace-top.
        add(0,1,0,16'hAAAA, 1,16'h1111,0,0,0, 1,0,16'hAAAA);
        add(0,1,1,16'hBBBB, 1,16'hAAAA,1,0,0, 1,0,16'hBBBB);
        add(0,0,1,16'h0000, 0,16'hBBBB,1,0,0, 0,0,16'h0000);
`ifdef STACK_BYPASS_EN
        add(0,1,1,16'h5A5A, 0,16'h5A5A,1,0,0, 1,0,16'hBBBB);
        add(1,0,0,16'h0000, 0,16'h5A5A,0,0,0, 0,0,16'h0000);
`else
        add(0,1,1,16'h5A5A, 1,16'hBBBB,0,0,1, 1,0,16'h5A5A);
        add(1,0,0,16'h0000, 0,16'hBBBB,0,0,0, 0,0,16'h0000);
`endif

        // Reset, with a push pending to confirm ram_load is held low.
        rst_n = 1'b0; clear = 1'b0; push = 1'b1; pop = 1'b0; din = 16'h7777;
        #12;
        chk_outs("reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("reset.ram_load", 32'(ram_load), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; push = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].psh, vecs[i].pp, vecs[i].din);
            chk_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout,
                     vecs[i].dv, vecs[i].ovf, vecs[i].unf);
            if (vecs[i].mchk)
                chk($sformatf("vec%0d.mem%0d", i, vecs[i].midx),
                    32'(mem[vecs[i].midx]), 32'(vecs[i].mval));
        end

        // Asynchronous reset mid-push at count=5 with dout_valid high.
        step(1, 0, 0, 16'h0000);
        for (int unsigned i = 0; i < 6; i++)
            step(0, 1, 0, 16'h0E00 + 16'(i));
        step(0, 0, 1, 16'h0000);
        chk_outs("pre_rst", 4'd5, 16'h0E05, 1'b1, 1'b0, 1'b0);
        push = 1'b1; din = 16'hFFFF;
        #1 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("async_rst.ram_load", 32'(ram_load), 32'd0);
        @(posedge clk);
        #1;
        chk("async_rst.mem5", 32'(mem[5]), 32'h0E05);
        @(negedge clk);
        rst_n = 1'b1; push = 1'b0;

        // clear with push at count=4: flush, no RAM write.
        for (int unsigned i = 0; i < 4; i++)
            step(0, 1, 0, 16'h0C00 + 16'(i));
        chk("pre_clear.count", 32'(count), 32'd4);
        snap = mem[4];
        @(negedge clk);
        clear = 1'b1; push = 1'b1; din = 16'hDEAD;
        #1;
        chk("clear.ram_load", 32'(ram_load), 32'd0);
        @(posedge clk);
        #1;
        chk_outs("clear", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("clear.mem4", 32'(mem[4]), 32'(snap));
        @(negedge clk);
        clear = 1'b0; push = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
